// File: rtl/mux4_pkg.sv
// Shared definitions for the 4-digit display demultiplexer: digit count,
// data widths, idle anode patterns for both polarities, and small helpers
// for classifying the normalised anode select.
package mux4_pkg;

  localparam int unsigned NDIGITS = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TOUT_W  = 8;

  // Anode drive that selects no digit, per polarity.
  localparam logic [NDIGITS-1:0] ANODE_IDLE_AL = 4'b1111;
  localparam logic [NDIGITS-1:0] ANODE_IDLE_AH = 4'b0000;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onehot_t;

  // Index of the single set bit; valid only when exactly one bit is set.
  function automatic onehot_t onehot_index(input logic [NDIGITS-1:0] v);
    onehot_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (v)
      4'b0001: r.idx = 2'd0;
      4'b0010: r.idx = 2'd1;
      4'b0100: r.idx = 2'd2;
      4'b1000: r.idx = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] popcount4(input logic [NDIGITS-1:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/digit_track.sv
// Per-digit recovery tracker.
// Filters the sampled value through a run-length stability check before
// updating the digit output, and flags the digit blanked after TIMEOUT
// consecutive samples in which it was not selected.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   active_i    : this digit is the single selected digit in this sample
//   muxd_i      : registered digit-bus value of this sample
//   out_o       : recovered digit value
//   blanked_o   : digit not selected for TIMEOUT samples
module digit_track
  import mux4_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active_i,
  input  logic [DIGIT_W-1:0] muxd_i,
  output logic [DIGIT_W-1:0] out_o,
  output logic               blanked_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_TGT  = CNT_W'(STABLE_CNT);
  localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_W'(TIMEOUT);

  logic [DIGIT_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] out_q, out_d;
  logic [TOUT_W-1:0]  tout_q, tout_d;
  logic               blanked_q, blanked_d;

  // Tracker state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      tout_q    <= '0;
      blanked_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      tout_q    <= tout_d;
      blanked_q <= blanked_d;
    end
  end

  // Candidate / stability count / timeout update.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    tout_d = tout_q;
    if (active_i) begin
      tout_d = '0;
      if (muxd_i == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cand_d = muxd_i;
        cnt_d  = CNT_W'(1);
      end
      // cand_d already holds muxd_i when the candidate was just replaced.
      if (cnt_d == CNT_TGT) out_d = cand_d;
    end else if (tout_q != TOUT_MAX) begin
      tout_d = tout_q + TOUT_W'(1);
    end
    blanked_d = (tout_d == TOUT_MAX);
  end

  assign out_o     = out_q;
  assign blanked_o = blanked_q;

endmodule

// File: rtl/mux4_demux.sv
// Receive-side demultiplexer for a 4-digit time-multiplexed display bus.
// Registers the digit bus and anode drive, normalises anode polarity,
// classifies each sample (idle / single digit / multi-hot), recovers the
// four digit values through per-digit trackers, and reports frame
// completion and multi-anode errors.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   muxd         : multiplexed digit value
//   adrive       : anode drive, bit i selects digit i
//   A, B, C, D   : recovered digit values
//   blanked      : bit i set when digit i has timed out
//   frame_done   : one-cycle pulse when every digit is seen or blanked
//   err          : sticky multi-anode error
module mux4_demux
  import mux4_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] muxd,
  input  logic [NDIGITS-1:0] adrive,
  output logic [DIGIT_W-1:0] A,
  output logic [DIGIT_W-1:0] B,
  output logic [DIGIT_W-1:0] C,
  output logic [DIGIT_W-1:0] D,
  output logic [NDIGITS-1:0] blanked,
  output logic               frame_done,
  output logic               err
);

  localparam logic [NDIGITS-1:0] ANODE_IDLE = ACTIVE_LOW ? ANODE_IDLE_AL : ANODE_IDLE_AH;

  logic [DIGIT_W-1:0] muxd_q;
  logic [NDIGITS-1:0] adrive_q;
  logic [NDIGITS-1:0] seen_q, seen_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;

  logic [NDIGITS-1:0] sel;
  logic               multi_hot;
  onehot_t            oh;
  logic [NDIGITS-1:0] active;
  logic [NDIGITS-1:0] blanked_w;
  logic [NDIGITS-1:0] contrib;
  logic [DIGIT_W-1:0] digit_out [NDIGITS];

  // Input sample registers plus frame/error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      muxd_q       <= '0;
      adrive_q     <= ANODE_IDLE;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      muxd_q       <= muxd;
      adrive_q     <= adrive;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Normalise polarity and classify the registered sample.
  always_comb begin
    sel       = ACTIVE_LOW ? ~adrive_q : adrive_q;
    multi_hot = (popcount4(sel) > 3'd1);
    oh        = onehot_index(sel);
    active    = '0;
    if (oh.valid) active = NDIGITS'(4'b0001 << oh.idx);
  end

  // Frame completion and sticky error; a multi-hot sample leaves seen alone.
  always_comb begin
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    contrib      = '0;
    if (multi_hot) begin
      err_d = 1'b1;
    end else begin
      contrib = active | blanked_w;
      if ((seen_q | contrib) == '1) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_q | contrib;
      end
    end
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    digit_track #(
      .STABLE_CNT(STABLE_CNT),
      .TIMEOUT   (TIMEOUT)
    ) u_track (
      .clk      (clk),
      .reset    (reset),
      .active_i (active[g]),
      .muxd_i   (muxd_q),
      .out_o    (digit_out[g]),
      .blanked_o(blanked_w[g])
    );
  end

  assign A          = digit_out[0];
  assign B          = digit_out[1];
  assign C          = digit_out[2];
  assign D          = digit_out[3];
  assign blanked    = blanked_w;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
